ysyx_23060201_wbu: RTL
======================

# ysyx_23060201_wbu

Write-back unit sitting directly upstream of the general-purpose register file. It accepts completed instructions from execute/LSU over a valid/ready handshake and formats load data (byte/half/word, signed/unsigned). Results are buffered in a 2-entry FIFO and drained one per cycle onto the register file's write port (`gpr_wen`/`gpr_waddr`/`gpr_wdata`). It also emits a per-instruction commit pulse with PC and a retired-instruction counter for difftest.

## Interface
- `GPR_ADDR_WIDTH`, 5, register index width.
- `DATA_WIDTH`, 32, data and PC width.

- `clk`  in  1  clock, rising edge; register file samples the write port on falling edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  FIFO can accept; high when occupancy < 2.
- `in_pc`  in  DATA_WIDTH  instruction PC.
- `in_rd`  in  GPR_ADDR_WIDTH  destination register.
- `in_rf_wen`  in  1  instruction writes a register.
- `in_is_load`  in  1  select formatted load data instead of `in_alu_res`.
- `in_ld_funct3`  in  3  load type.
- `in_addr_lo`  in  2  low bits of the load address.
- `in_alu_res`  in  DATA_WIDTH  ALU/CSR/link result.
- `in_ld_raw`  in  DATA_WIDTH  aligned memory word.
- `wb_stall`  in  1  hold the FIFO head; no drain this cycle.
- `gpr_wen`  out  1  register-file write enable.
- `gpr_waddr`  out  GPR_ADDR_WIDTH  register-file write address.
- `gpr_wdata`  out  DATA_WIDTH  register-file write data.
- `commit_valid`  out  1  one-cycle pulse per drained instruction.
- `commit_pc`  out  DATA_WIDTH  PC of the drained instruction.
- `retire_cnt`  out  32  count of drained instructions.
- `byp_raddr1`, `byp_raddr2`  in  GPR_ADDR_WIDTH  decode read indices.
- `byp_hit1`, `byp_hit2`  out  1  pending write matches.
- `byp_data1`, `byp_data2`  out  DATA_WIDTH  pending data.

## Operation
- Push when `in_valid && in_ready`. The entry stores {pc, rd, wen_eff, data}.
  - `wen_eff = in_rf_wen && (in_rd != 0)`.
  - `data` is computed at push time.
- Load formatting, with byte selected by `in_addr_lo` and half selected by `in_addr_lo[1]`:
  - 000 `lb`: sign-extend byte.
  - 001 `lh`: sign-extend half.
  - 100 `lbu`: zero-extend byte.
  - 101 `lhu`: zero-extend half.
  - All other codes: full word.
  - `in_addr_lo[0]` is ignored for half loads.
- Non-load entries store `in_alu_res` unchanged.
- Drain: when occupancy > 0 and `!wb_stall`, the head is presented and popped at the next rising edge.
- Write port:
  - `gpr_wen` = head valid && `!wb_stall` && head `wen_eff`.
  - `gpr_waddr`/`gpr_wdata` = head fields. They are 0 when the FIFO is empty.
- `commit_valid` = head valid && `!wb_stall`. It pulses even when `wen_eff` = 0 (stores, branches, rd = x0).
- `retire_cnt` increments on each pop and wraps 0xFFFFFFFF -> 0.
- Storage: 2 entries with 1-bit read/write pointers and a 2-bit count.
  - Push and pop may occur in the same cycle. Count is unchanged; ordering is preserved.
- Full: `in_ready` = 0 even if a pop occurs that cycle. There is no combinational path from `wb_stall` to `in_ready`.
- Empty: no write, no commit. A pushed entry is never written in the same cycle it is pushed.

## Timing
- Latency: push at rising edge N; `gpr_wen` is high during cycle N+1. The register file captures at the falling edge of N+1, and the pop occurs at rising edge N+1.
- Throughput: 1 instruction/cycle sustained with `in_valid` held high and no stall.
- Reset (`rst` low, asynchronous) forces:
  - count, pointers, `retire_cnt` = 0;
  - `gpr_wen` = 0 and `commit_valid` = 0;
  - `gpr_waddr`/`gpr_wdata`/`commit_pc` = 0;
  - `in_ready` = 1;
  - `byp_hit*` = 0.
- Reset asserted mid-operation discards all buffered entries. No partial write is issued.
- All outputs are combinational from registered state, except `gpr_wen` and `commit_valid`, which are also gated by `wb_stall`.

## Configuration
- `YSYX_23060201_WBU_BYPASS_EN` defined:
  - `byp_hitK` = 1 if any valid FIFO entry has `wen_eff` and `rd == byp_raddrK`.
  - `byp_dataK` = that entry's data. The youngest entry wins when both match.
  - Index 0 never hits.
- Macro undefined: the bypass ports remain, `byp_hit*` and `byp_data*` are tied to 0, and no comparators are built.

## Test plan
- Single `addi` result: rd = 5, `in_alu_res` = 0x12345678, pushed at edge N -> `gpr_wen` = 1, `gpr_waddr` = 5, `gpr_wdata` = 0x12345678 in cycle N+1, `commit_valid` pulses once, `retire_cnt` = 1.
- Loads with `in_ld_raw` = 0x80FF7F01:
  - `lb` at `addr_lo` = 3 -> 0xFFFFFF80.
  - `lbu` at `addr_lo` = 1 -> 0x0000007F.
  - `lh` at `addr_lo` = 2 -> 0xFFFF80FF.
  - `lhu` at `addr_lo` = 0 -> 0x00007F01.
  - `lw` -> 0x80FF7F01.
- rd = 0 with `in_rf_wen` = 1, data 0xDEADBEEF -> `gpr_wen` = 0, `commit_valid` = 1, `retire_cnt` increments.
- Hold `wb_stall` = 1 and push 3 times -> `in_ready` drops after 2 pushes. Release the stall -> writes drain in push order on consecutive cycles, then `in_ready` returns to 1.
- Assert `rst` low with 2 entries pending -> outputs go to reset values immediately. After release, no stale write or commit appears.
- With `YSYX_23060201_WBU_BYPASS_EN` defined, stall while x7 = 1 (older) and x7 = 2 (younger) are pending -> `byp_raddr1` = 7 gives hit = 1, data = 2. `byp_raddr2` = 0 gives hit = 0.

Source files
------------

// File: rtl/ysyx_23060201_wbu.sv
// Write-back unit: formats load data, buffers results in a 2-entry FIFO and drains one per cycle to the GPR write port.
// Optional decode bypass of pending writes is enabled by defining YSYX_23060201_WBU_BYPASS_EN.
module ysyx_23060201_wbu #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [GPR_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rf_wen,
  input  logic                      in_is_load,
  input  logic [2:0]                in_ld_funct3,
  input  logic [1:0]                in_addr_lo,
  input  logic [DATA_WIDTH-1:0]     in_alu_res,
  input  logic [DATA_WIDTH-1:0]     in_ld_raw,
  input  logic                      wb_stall,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      commit_valid,
  output logic [DATA_WIDTH-1:0]     commit_pc,
  output logic [31:0]               retire_cnt,
  input  logic [GPR_ADDR_WIDTH-1:0] byp_raddr1,
  input  logic [GPR_ADDR_WIDTH-1:0] byp_raddr2,
  output logic                      byp_hit1,
  output logic                      byp_hit2,
  output logic [DATA_WIDTH-1:0]     byp_data1,
  output logic [DATA_WIDTH-1:0]     byp_data2
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [GPR_ADDR_WIDTH-1:0] rd;
    logic                      wen;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [2:0]            f3,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] raw
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] res;
    case (lo)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      2'd3:    b = raw[31:24];
      default: b = 8'h00;
    endcase
    // bit 0 of the address is deliberately ignored for halfword selection
    if (lo[1]) begin
      h = raw[31:16];
    end else begin
      h = raw[15:0];
    end
    case (f3)
      3'b000:  res = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  res = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, h};
      default: res = raw;
    endcase
    return res;
  endfunction

  entry_t                r_entry [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic [31:0]           r_retire;

  entry_t                w_new;
  entry_t                w_head;
  logic                  w_nonempty;
  logic                  w_push;
  logic                  w_pop;

  assign w_nonempty = (r_count != 2'd0);
  assign in_ready   = (r_count != 2'd2);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = w_nonempty && !wb_stall;
  assign w_head     = r_entry[r_rptr];

  // Build the entry to be stored on push
  always_comb begin
    w_new.pc  = in_pc;
    w_new.rd  = in_rd;
    w_new.wen = in_rf_wen && (in_rd != '0);
    if (in_is_load) begin
      w_new.data = fmt_load(in_ld_funct3, in_addr_lo, in_ld_raw);
    end else begin
      w_new.data = in_alu_res;
    end
  end

  // FIFO storage, pointers, occupancy and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_entry[i] <= '0;
      end
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_retire <= 32'd0;
    end else begin
      if (w_push) begin
        r_entry[r_wptr] <= w_new;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr   <= ~r_rptr;
        r_retire <= r_retire + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign gpr_wen      = w_pop && w_head.wen;
  assign commit_valid = w_pop;
  assign gpr_waddr    = w_nonempty ? w_head.rd   : '0;
  assign gpr_wdata    = w_nonempty ? w_head.data : '0;
  assign commit_pc    = w_nonempty ? w_head.pc   : '0;
  assign retire_cnt   = r_retire;

`ifdef YSYX_23060201_WBU_BYPASS_EN
  function automatic logic [DATA_WIDTH:0] byp_lookup(
    input logic [GPR_ADDR_WIDTH-1:0] raddr,
    input entry_t                    old_e,
    input logic                      old_v,
    input entry_t                    yng_e,
    input logic                      yng_v
  );
    logic old_hit;
    logic yng_hit;
    logic [DATA_WIDTH:0] res;
    old_hit = old_v && old_e.wen && (old_e.rd == raddr) && (raddr != '0);
    yng_hit = yng_v && yng_e.wen && (yng_e.rd == raddr) && (raddr != '0);
    // the younger pending write is the architecturally newest value
    if (yng_hit) begin
      res = {1'b1, yng_e.data};
    end else if (old_hit) begin
      res = {1'b1, old_e.data};
    end else begin
      res = '0;
    end
    return res;
  endfunction

  entry_t w_young;
  logic   w_young_v;
  assign w_young   = r_entry[~r_rptr];
  assign w_young_v = (r_count == 2'd2);

  assign {byp_hit1, byp_data1} = byp_lookup(byp_raddr1, w_head, w_nonempty, w_young, w_young_v);
  assign {byp_hit2, byp_data2} = byp_lookup(byp_raddr2, w_head, w_nonempty, w_young, w_young_v);
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{byp_raddr1, byp_raddr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule
